// File: rtl/vc_biu_fifo_wr_arb.sv
// Round-robin write arbiter sharing one BIU FIFO write port among NUM_REQ requesters, with burst locking.
// Optional starvation escalation is compiled in with `define VC_BIU_FIFO_WR_ARB_STARVE_EN.
module vc_biu_fifo_wr_arb #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_MAX    = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int IDW         = $clog2(NUM_REQ),
  localparam int CW          = $clog2(BURST_MAX) + 1
) (
  input  logic                          core_clk,
  input  logic                          core_reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_en,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          lock_vld,
  output logic [IDW-1:0]                lock_id,
  output logic                          dbg_state_o,
  output logic [IDW-1:0]                dbg_rr_ptr_o,
  output logic [CW-1:0]                 dbg_beat_cnt_o
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

  state_e          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  lock_id_q;
  logic [CW-1:0]   beat_cnt_q;
  logic            lock_vld_q;

  logic            can_wr;
  logic            rr_found;
  logic [IDW-1:0]  rr_win;
  logic [IDW-1:0]  cand;
  logic            win_found;
  logic [IDW-1:0]  win;
  logic            gnt_vld;
  logic [IDW-1:0]  gnt_idx;
  logic            last_g;
  logic [IDW-1:0]  ptr_next;

  assign can_wr = fifo_wr_en & ~fifo_full;

  // First requester at or above rr_ptr, wrapping past NUM_REQ-1 back to 0.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_win   = cand;
      end
    end
  end

`ifdef VC_BIU_FIFO_WR_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]  wait_q [NUM_REQ];
  logic           st_found;
  logic [IDW-1:0] st_win;

  always_comb begin
    st_found = 1'b0;
    st_win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!st_found && req[i] && (wait_q[i] == SW'(STARVE_LIMIT))) begin
        st_found = 1'b1;
        st_win   = IDW'(i);
      end
    end
  end

  // Wait counters saturate at the limit and only clear on a grant.
  always_ff @(posedge core_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) begin
          wait_q[i] <= '0;
        end else if (req[i] && (wait_q[i] != SW'(STARVE_LIMIT))) begin
          wait_q[i] <= wait_q[i] + 1'b1;
        end
      end
    end
  end

  assign win_found = st_found | rr_found;
  assign win       = st_found ? st_win : rr_win;
`else
  assign win_found = rr_found;
  assign win       = rr_win;
`endif

  // Zero-latency grant; in LOCK only the owner can be granted.
  always_comb begin
    gnt_idx = win;
    gnt_vld = can_wr & win_found;
    if (state_q == LOCK) begin
      gnt_idx = lock_id_q;
      gnt_vld = can_wr & req[lock_id_q];
    end
    if (!core_reset_n) gnt_vld = 1'b0;
  end

  always_comb begin
    gnt          = '0;
    fifo_wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_vld && (gnt_idx == IDW'(i))) begin
        gnt[i]       = 1'b1;
        fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign fifo_wr  = gnt_vld;
  assign last_g   = req_last[gnt_idx];
  assign ptr_next = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge core_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_id_q  <= '0;
      beat_cnt_q <= '0;
      lock_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            if (last_g || (BURST_MAX == 1)) begin
              rr_ptr_q <= ptr_next;
            end else begin
              state_q    <= LOCK;
              lock_id_q  <= gnt_idx;
              beat_cnt_q <= CW'(1);
              lock_vld_q <= 1'b1;
            end
          end
        end
        LOCK: begin
          if (gnt_vld) begin
            if (last_g || (beat_cnt_q == CW'(BURST_MAX - 1))) begin
              state_q    <= IDLE;
              rr_ptr_q   <= ptr_next;
              beat_cnt_q <= '0;
              lock_vld_q <= 1'b0;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          lock_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign lock_vld       = lock_vld_q;
  assign lock_id        = lock_id_q;
  assign dbg_state_o    = (state_q == LOCK);
  assign dbg_rr_ptr_o   = rr_ptr_q;
  assign dbg_beat_cnt_o = beat_cnt_q;

endmodule

// File: doc/vc_biu_fifo_wr_arb.md
Name: vc_biu_fifo_wr_arb

Overview:
- Write-side arbiter that shares one BIU synchronous FIFO among NUM_REQ requesters.
- Picks at most one requester per cycle, round-robin, and drives the FIFO write port (wr, wr_data).
- Supports multi-beat bursts: one requester keeps the port until its last beat or until BURST_MAX beats, whichever comes first.
- Sits between the BIU request sources and the FIFO's write interface.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_WIDTH, 32: data width, equal to the FIFO DATA_WIDTH.
- BURST_MAX, 4: maximum beats per lock, 1..16; beat counter width is $clog2(BURST_MAX)+1.
- STARVE_LIMIT, 8: wait cycles before a requester is escalated; used only with the optional feature.

Ports:
- core_clk  in  1  single clock, rising edge.
- core_reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester write request.
- req_last  in  NUM_REQ  marks the final beat of a burst.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i's data in slice [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  NUM_REQ  one-hot grant; a beat is accepted in the cycle gnt[i]=1.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  in  1  FIFO write-side enable.
- fifo_wr  out  1  write strobe to the FIFO.
- fifo_wr_data  out  DATA_WIDTH  write data to the FIFO.
- lock_vld  out  1  burst lock held.
- lock_id  out  $clog2(NUM_REQ)  current lock owner.

Behaviour:
- Clock and reset: one clock, core_clk. Reset is asynchronous and active-low (core_reset_n).
- Reset values: state=IDLE, rr_ptr=0, beat_cnt=0, lock_vld=0, lock_id=0. gnt, fifo_wr and fifo_wr_data are forced to 0 while core_reset_n=0.
- can_wr = fifo_wr_en & ~fifo_full. With can_wr=0, gnt=0 and state holds (no beat is counted).
- gnt is combinational from req, state and can_wr: zero-latency grant, data accepted the same cycle.
- fifo_wr = |gnt. fifo_wr_data = req_data slice of the granted index, else 0.
- At most one gnt bit is set in any cycle.
- IDLE:
  - The winner is the first set req scanning upward from rr_ptr, wrapping at NUM_REQ-1 to 0.
  - Winner with req_last=1, or BURST_MAX=1: single beat; stay IDLE; rr_ptr = winner+1 mod NUM_REQ.
  - Winner with req_last=0: go to LOCK; lock_id=winner; beat_cnt=1.
- LOCK:
  - Only lock_id may be granted; all other requesters see gnt=0.
  - Beat granted with req_last=1, or beat_cnt+1==BURST_MAX: return to IDLE; rr_ptr = lock_id+1 mod NUM_REQ; beat_cnt=0.
  - Other granted beats: beat_cnt increments by 1.
  - req[lock_id]=0: lock held, no grant, counter unchanged. Requesters must not abandon a burst.
- lock_vld=1 exactly while in LOCK.
- Boundaries:
  - fifo_full asserted mid-burst: stall in LOCK with no beat lost.
  - No requests in IDLE: gnt=0, rr_ptr unchanged.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Reset asserted mid-burst: immediately back to the reset values; the partial burst is the requester's responsibility.

Optional Feature:
- Macro: VC_BIU_FIFO_WR_ARB_STARVE_EN.
- Defined:
  - Each requester has a wait counter that increments every cycle req[i]=1 & gnt[i]=0, saturating at STARVE_LIMIT.
  - The counter clears on gnt[i] and on reset.
  - In IDLE, any requester at STARVE_LIMIT wins over round-robin; among several, the lowest index wins.
  - rr_ptr update and LOCK behaviour are unchanged.
- Undefined: pure round-robin; no counters are instantiated.

Test Plan:
- Reset, then req=4'b1111, all req_last=1, can_wr=1 for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,...; fifo_wr=1 every cycle; fifo_wr_data follows the granted slice.
- req[2] burst with req_last=0,0,1, and req[0]=1 throughout -> gnt=0100 for 3 cycles with lock_vld=1 and lock_id=2, then gnt=0001, rr_ptr=3.
- req[1] holds req_last=0 for 6 beats, BURST_MAX=4 -> 4 grants, lock released, req[3] granted, then req[1] regranted via round-robin.
- fifo_full=1 for 3 cycles during a locked burst -> gnt=0, beat_cnt frozen, burst resumes afterward with no missing or duplicated data.
- core_reset_n pulsed low during LOCK at beat 2 -> lock_vld=0, gnt=0 immediately; after release, the next grant goes to index 0 (rr_ptr=0).
- With the STARVE_EN macro defined, STARVE_LIMIT=3, and req[0] continuously bursting BURST_MAX beats: req[3] is granted at the first IDLE cycle after its counter reaches 3, ahead of round-robin order.
